// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU: single-cycle ops complete on the accepting edge,
// MUL/MULH run a WIDTH-step shift-add multiplier before presenting the result.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             CarryOut,
  output logic             Zero,
  output logic             Overflow,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4,  OP_NOT  = 4'd5,  OP_SHL1 = 4'd6,  OP_SHR1 = 4'd7;
  localparam logic [3:0] OP_ROL1 = 4'd8,  OP_MUL  = 4'd9,  OP_MULH = 4'd10, OP_SLT  = 4'd11;
  localparam logic [3:0] OP_SLL  = 4'd12, OP_SRL  = 4'd13, OP_SRA  = 4'd14, OP_PASS = 4'd15;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mulh_q, mulh_d;

  // Single-cycle datapath, evaluated on the live inputs at the accepting edge
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] f_res;
  logic             f_c, f_v, big_shift;

  always_comb begin
    sum       = {1'b0, A} + {1'b0, B};
    diff      = {1'b0, A} - {1'b0, B};
    big_shift = 32'(B) >= WIDTH;
    f_res     = '0;
    f_c       = 1'b0;
    f_v       = 1'b0;
    case (ALU_Sel)
      OP_ADD: begin
        f_res = sum[WIDTH-1:0];
        f_c   = sum[WIDTH];
        f_v   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        f_res = diff[WIDTH-1:0];
        f_c   = diff[WIDTH];
        f_v   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  f_res = A & B;
      OP_OR:   f_res = A | B;
      OP_XOR:  f_res = A ^ B;
      OP_NOT:  f_res = ~A;
      OP_SHL1: begin
        f_res = {A[WIDTH-2:0], 1'b0};
        f_c   = A[WIDTH-1];
      end
      OP_SHR1: begin
        f_res = {1'b0, A[WIDTH-1:1]};
        f_c   = A[0];
      end
      OP_ROL1: begin
        f_res = {A[WIDTH-2:0], A[WIDTH-1]};
        f_c   = A[WIDTH-1];
      end
      OP_SLT:  f_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLL:  f_res = big_shift ? '0 : (A << B);
      OP_SRL:  f_res = big_shift ? '0 : (A >> B);
      OP_SRA: begin
        if (big_shift) f_res = {WIDTH{A[WIDTH-1]}};
        else           f_res = $signed(A) >>> B;
      end
      OP_PASS: f_res = B;
      default: f_res = '0;
    endcase
  end

  // One shift-add step: {hi,lo} holds the partial product with the
  // unconsumed multiplier bits in the low half.
  logic [WIDTH:0]   step_sum;
  logic [WIDTH-1:0] nx_hi, nx_lo, mul_res;

  always_comb begin
    step_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    nx_hi    = step_sum[WIDTH:1];
    nx_lo    = {step_sum[0], lo_q[WIDTH-1:1]};
    mul_res  = mulh_q ? nx_hi : nx_lo;
  end

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    res_d       = res_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    mcand_d     = mcand_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
    mulh_d      = mulh_q;
    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          in_ready_d = 1'b0;
          if (ALU_Sel == OP_MUL || ALU_Sel == OP_MULH) begin
            mcand_d = A;
            lo_d    = B;
            hi_d    = '0;
            cnt_d   = '0;
            mulh_d  = (ALU_Sel == OP_MULH);
            busy_d  = 1'b1;
            state_d = BUSY;
          end else begin
            res_d       = f_res;
            carry_d     = f_c;
            ovf_d       = f_v;
            zero_d      = (f_res == '0);
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
        end
      end
      BUSY: begin
        hi_d  = nx_hi;
        lo_d  = nx_lo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) begin
          res_d       = mul_res;
          carry_d     = 1'b0;
          ovf_d       = !mulh_q && (nx_hi != '0);
          zero_d      = (mul_res == '0);
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      mcand_q     <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      mulh_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      res_q       <= res_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      mcand_q     <= mcand_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      cnt_q       <= cnt_d;
      mulh_q      <= mulh_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign ALU_Out   = res_q;
  assign CarryOut  = carry_q;
  assign Zero      = zero_q;
  assign Overflow  = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized + directed bench for alu_seq against an integer-arithmetic model.
module tb_alu_seq;
  localparam int W    = 8;
  localparam int M    = (1 << W) - 1;
  localparam int MAXS = (1 << (W-1)) - 1;
  localparam int MINS = -(1 << (W-1));

  logic         clk = 1'b0, rst = 1'b1;
  logic         in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic [3:0]   ALU_Sel = '0;
  logic         in_ready, out_valid, CarryOut, Zero, Overflow, busy;
  logic [W-1:0] ALU_Out;

  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALU_Sel(ALU_Sel), .out_valid(out_valid), .out_ready(out_ready),
    .ALU_Out(ALU_Out), .CarryOut(CarryOut), .Zero(Zero), .Overflow(Overflow), .busy(busy)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sx(input int x);
    return (x > MAXS) ? x - (1 << W) : x;
  endfunction

  task automatic model(input int op, input int a, input int b,
                       output int r, output int c, output int v);
    int sa, sb, t;
    sa = sx(a); sb = sx(b);
    r = 0; c = 0; v = 0;
    case (op)
      0:  begin t = a + b; r = t & M; c = t >> W; t = sa + sb; v = int'(t > MAXS || t < MINS); end
      1:  begin r = (a - b) & M; c = int'(a < b); t = sa - sb; v = int'(t > MAXS || t < MINS); end
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = ~a & M;
      6:  begin r = (a << 1) & M; c = a >> (W-1); end
      7:  begin r = a >> 1; c = a & 1; end
      8:  begin r = ((a << 1) | (a >> (W-1))) & M; c = a >> (W-1); end
      9:  begin t = a * b; r = t & M; v = int'((t >> W) != 0); end
      10: r = (a * b) >> W;
      11: r = int'(sa < sb);
      12: r = (b >= W) ? 0 : ((a << b) & M);
      13: r = (b >= W) ? 0 : (a >> b);
      14: r = (b >= W) ? ((sa < 0) ? M : 0) : ((sa >>> b) & M);
      default: r = b;
    endcase
  endtask

  task automatic do_op(input int op, input int a, input int b, input int bp);
    int r, c, v, lat, nb, g, exp_lat;
    model(op, a, b, r, c, v);
    g = 0;
    while (!in_ready && g < 20) begin tick(); g++; end
    chk("pre_in_ready", in_ready, 1);
    A = W'(a); B = W'(b); ALU_Sel = 4'(op); in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0; A = W'($urandom); B = W'($urandom); ALU_Sel = 4'($urandom);
    lat = 0; nb = 0;
    while (!out_valid && lat < 40) begin
      if (busy) nb++;
      tick();
      lat++;
    end
    exp_lat = (op == 9 || op == 10) ? W : 0;
    chk($sformatf("op%0d_latency", op), lat, exp_lat);
    chk($sformatf("op%0d_busy_cycles", op), nb, exp_lat);
    chk($sformatf("op%0d_out a=%0h b=%0h", op, a, b), ALU_Out, r);
    chk($sformatf("op%0d_carry", op), CarryOut, c);
    chk($sformatf("op%0d_ovf", op), Overflow, v);
    chk($sformatf("op%0d_zero", op), Zero, int'(r == 0));
    chk("done_in_ready", in_ready, 0);
    for (int k = 0; k < bp; k++) begin
      in_valid = 1'b1; A = W'($urandom); B = W'($urandom); ALU_Sel = 4'($urandom);
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_out", ALU_Out, r);
      chk("hold_flags", {CarryOut, Overflow, Zero}, {c[0], v[0], r == 0});
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_out"}, ALU_Out, 0);
    chk({tag, "_flags"}, {CarryOut, Zero, Overflow}, 0);
  endtask

  initial begin
    int op, a, b;
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();
    chk("post_reset_in_ready", in_ready, 1);

    do_op(0, 200, 100, 0);
    do_op(1, 100, 101, 0);
    do_op(1, 'h80, 1, 0);
    do_op(1, 5, 5, 0);
    do_op(9, 200, 3, 0);
    do_op(10, 200, 3, 0);
    do_op(9, 13, 11, 0);
    do_op(14, 'h90, 2, 0);
    do_op(14, 'h90, 9, 0);
    do_op(12, 'h81, 8, 0);
    do_op(6, 'hAA, 0, 0);
    do_op(11, 'hFF, 1, 0);
    do_op(9, 255, 255, 3);
    do_op(4, 'h5A, 'h3C, 3);

    // Abort a MUL on its 4th BUSY cycle
    A = 8'd200; B = 8'd3; ALU_Sel = 4'd9; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("abort_busy_before", busy, 1);
    rst = 1'b1;
    tick();
    chk_reset_outputs("abort");
    rst = 1'b0;
    tick();
    chk("abort_in_ready", in_ready, 1);
    chk("abort_no_valid", out_valid, 0);
    do_op(0, 3, 1, 0);

    // rst beats a simultaneous in_valid
    rst = 1'b1; in_valid = 1'b1; A = 8'd7; B = 8'd7; ALU_Sel = 4'd0;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    repeat (3) tick();
    chk("rst_vs_valid_no_out", out_valid, 0);
    chk("rst_vs_valid_in_ready", in_ready, 1);

    repeat (300) begin
      op = $urandom_range(0, 15);
      a  = $urandom_range(0, M);
      b  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, W + 2) : $urandom_range(0, M);
      do_op(op, a, b, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the 4-bit combinational ALU.
- Keeps opcodes 0-7 bit-compatible, widened to WIDTH bits. Adds variable shifts, signed compare, and an iterative unsigned multiplier. Adds Zero/Overflow flags and valid/ready handshaking on both sides.
- Sits between an operand-issuing controller and a result consumer. Processes one operation at a time and operands are latched on acceptance.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 4..32.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, operand/opcode presented.
- in_ready, output, 1, block can accept an operation.
- A, input, WIDTH, operand A.
- B, input, WIDTH, operand B; also the shift amount for ops 12-14.
- ALU_Sel, input, 4, opcode.
- out_valid, output, 1, result/flags valid.
- out_ready, input, 1, consumer takes the result.
- ALU_Out, output, WIDTH, result.
- CarryOut, output, 1, carry/borrow/shifted-out bit.
- Zero, output, 1, 1 when ALU_Out == 0 (qualified by out_valid).
- Overflow, output, 1, signed overflow / multiply overflow.
- busy, output, 1, high in BUSY state.

Behaviour:
- Clock and reset: one clock domain, clk; reset rst is synchronous, active-high.
- Reset values: in_ready=0 while rst is high, then 1 in the first cycle after rst deasserts. out_valid=0, busy=0, ALU_Out=0, CarryOut=0, Zero=0, Overflow=0. State=IDLE.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch A, B and ALU_Sel. Opcode 9/10 goes to BUSY; every other opcode computes, registers the result and goes to DONE.
  - BUSY: shift-add multiply, one multiplier bit per cycle, WIDTH cycles, then register the result and go to DONE. in_ready=0, busy=1.
  - DONE: out_valid=1 and outputs held stable. When out_ready=1, go to IDLE; out_valid drops and in_ready rises on the same edge.
- Latency, counted from the accepting edge N:
  - Single-cycle ops: out_valid visible from edge N+1.
  - MUL/MULH: out_valid visible from edge N+WIDTH+1.
  - Throughput is one op per (latency+1) cycles minimum; there is no overlap.
- Input stability: A, B and ALU_Sel may change freely after acceptance; only the latched copies are used.
- Opcodes (all 16 defined):
  - 0 ADD: {CarryOut,ALU_Out}=A+B. Overflow=signed overflow.
  - 1 SUB: {CarryOut,ALU_Out}=A-B, so CarryOut=borrow (1 iff A<B unsigned). Overflow=signed overflow.
  - 2 AND, 3 OR, 4 XOR, 5 NOT A: CarryOut=0, Overflow=0.
  - 6 SHL1: ALU_Out=A<<1, CarryOut=A[WIDTH-1].
  - 7 SHR1: ALU_Out=A>>1 (logical), CarryOut=A[0].
  - 8 ROL1: rotate left by 1, CarryOut=A[WIDTH-1].
  - 9 MUL: low WIDTH bits of unsigned A*B. Overflow=1 iff the high half is nonzero.
  - 10 MULH: high WIDTH bits of unsigned A*B. Overflow=0.
  - 11 SLT: ALU_Out=1 if signed A < signed B, else 0.
  - 12 SLL, 13 SRL, 14 SRA by B (unsigned):
    - If B>=WIDTH, result is 0 for SLL/SRL and all sign bits for SRA.
    - If B=0, result is A.
    - CarryOut=0.
  - 15 PASS B.
  - Overflow=0 for every opcode not listed with it; CarryOut=0 for 2-5 and 9-15.
- Zero: computed from the registered ALU_Out for every opcode, including MUL/MULH.
- Handshake rules:
  - in_valid while not in IDLE is ignored; there is no queueing.
  - out_ready while not in DONE has no effect.
- Reset mid-operation: rst high in any state aborts the operation. No out_valid is produced for it and all outputs return to their reset values on that edge.
- Simultaneous rst and in_valid: rst wins, the op is not accepted.

Test Plan:
- WIDTH=8, ADD A=200 B=100 → ALU_Out=44, CarryOut=1, Overflow=0, Zero=0. out_valid exactly 1 cycle after the accepting edge.
- SUB cases:
  - A=100 B=101 → 0xFF, CarryOut=1, Overflow=0.
  - A=0x80 B=0x01 → 0x7F, Overflow=1.
  - A=5 B=5 → 0, Zero=1, CarryOut=0.
- MUL A=200 B=3 → 0x58, Overflow=1, busy high 8 cycles, out_valid at edge N+9. MULH same operands → 0x02. MUL A=13 B=11 → 0x8F, Overflow=0.
- Shifts:
  - SRA A=0x90 B=2 → 0xE4.
  - SRA B=9 → 0xFF.
  - SLL A=0x81 B=8 → 0.
  - SHL1 A=0xAA → 0x54, CarryOut=1.
  - SLT A=0xFF B=0x01 → 1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE → ALU_Out and flags stable, in_ready=0, and a new in_valid is ignored. Release → in_ready=1 the next cycle.
- Assert rst on the 4th BUSY cycle of a MUL → next cycle all outputs 0, no out_valid. in_ready=1 the cycle after rst drops, and a fresh ADD 3+1 returns 4.
